// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words and writes them
// at word-aligned addresses while holding the CPU. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ASSEMBLE,
    S_WRITE,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam logic [CNT_W:0] WORDS_L = (CNT_W + 1)'(WORDS);

  state_t           r_state;
  logic [CNT_W-1:0] r_remain;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_asm;
  logic             r_byte_ready;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_busy;
  logic             r_done;
  logic             r_load_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  // Byte transfers only happen while byte_ready is up, which is only in ASSEMBLE/VERIFY.
  logic w_xfer;
  assign w_xfer = byte_valid && r_byte_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_remain     <= '0;
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= BASE_ADDR;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_remain   <= word_count;
            r_wr_addr  <= BASE_ADDR;
            r_load_err <= 1'b0;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_CHECK;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end
        S_CHECK: begin
          if (r_remain == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if ({1'b0, r_remain} > WORDS_L) begin
            r_load_err <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_byte_ready <= 1'b1;
            r_state      <= S_ASSEMBLE;
          end
        end
        S_ASSEMBLE: begin
          if (w_xfer) begin
            r_asm      <= {r_asm[15:0], byte_data};
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ byte_data;
`endif
            // First byte ends up in the MSB after four shifts.
            if (r_byte_idx == 2'd3) begin
              r_wr_data    <= {r_asm, byte_data};
              r_wr_en      <= 1'b1;
              r_byte_ready <= 1'b0;
              r_state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_wr_addr <= r_wr_addr + 32'd4;
          r_remain  <= r_remain - 1'b1;
          if (r_remain == CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_byte_ready <= 1'b1;
            r_state      <= S_VERIFY;
`else
            r_done  <= 1'b1;
            r_state <= S_DONE;
`endif
          end else begin
            r_byte_ready <= 1'b1;
            r_state      <= S_ASSEMBLE;
          end
        end
        S_VERIFY: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_xfer) begin
            if (byte_data != r_csum) r_load_err <= 1'b1;
            r_byte_ready <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end
`else
          r_byte_ready <= 1'b0;
          r_state      <= S_IDLE;
`endif
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign cpu_hold   = r_busy;
  assign done       = r_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// checked by a negedge monitor whenever wr_en is seen.
module tb_imem_loader;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_start;
  logic [CNT_W-1:0] word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             cpu_hold;
  logic             done;
  logic             load_err;

  imem_loader #(.WORDS(64), .BASE_ADDR(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] byte_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int busy_cyc = 0;
  bit ready_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every write and tracks pulses/levels.
  always @(negedge clock) begin
    if (busy) busy_cyc++;
    if (byte_ready) ready_seen = 1;
    if (done) done_cnt++;
    if (busy || cpu_hold) chk("cpu_hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
    if (wr_en) begin
      wr_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h:%h required=none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.a);
        chk("wr_data", wr_data, e.d);
        $display("write addr=%h data=%h", wr_addr, wr_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!acc && t < 200) begin
      @(negedge clock);
      acc = byte_ready;
      @(posedge clock);
      #1;
      t++;
    end
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] wc);
    word_count = wc;
    load_start = 1'b1;
    @(posedge clock);
    #1;
    load_start = 1'b0;
  endtask

  // Sends byte_q as a full load of wc words; checksum byte appended when the feature is on.
  task automatic run_load(input logic [CNT_W-1:0] wc, input int gap);
    int d0;
    logic [7:0] cs;
    d0 = done_cnt;
    busy_cyc = 0;
    cs = 8'h00;
    pulse_start(wc);
    foreach (byte_q[i]) begin
      send_byte(byte_q[i], gap);
      cs = cs ^ byte_q[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, 0);
`endif
    wait_done(d0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int w0;
    int d0;
    logic [7:0] cs;
    reset = 1'b1;
    load_start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Two words, byte_valid held high: busy spans CHECK + 2*(4 bytes + WRITE) + DONE.
    byte_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
    exp_q.push_back('{32'h0000_0000, 32'h2008_0005});
    exp_q.push_back('{32'h0000_0004, 32'hAC09_0000});
    run_load(2, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("busy_cycles_2w", 32'(busy_cyc), 32'd13);
`else
    chk("busy_cycles_2w", 32'(busy_cyc), 32'd12);
`endif
    chk("addr_after_2w", wr_addr, 32'h0000_0008);
    chk("data_hold_2w", wr_data, 32'hAC09_0000);
    chk("err_2w", {31'd0, load_err}, 32'd0);
    $display("load wc=2 done");

    // One word with byte_valid toggling every cycle.
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_q.push_back('{32'h0000_0000, 32'h0102_0304});
    run_load(1, 1);
    chk("addr_after_toggle", wr_addr, 32'h0000_0004);
    $display("load wc=1 toggled done");

    // Zero words: done two cycles after load_start, no writes.
    w0 = wr_cnt;
    word_count = 16'd0;
    load_start = 1'b1;
    @(posedge clock);
    #1;
    load_start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("zero_done_latency", 32'(n), 32'd2);
    chk("zero_load_err", {31'd0, load_err}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("zero_no_writes", 32'(wr_cnt - w0), 32'd0);
    $display("load wc=0 done latency=%0d", n);

    // Oversized count: error, no bytes ever accepted even with data offered.
    ready_seen = 0;
    w0 = wr_cnt;
    d0 = done_cnt;
    byte_valid = 1'b1;
    byte_data = 8'h55;
    pulse_start(16'd65);
    wait_done(d0);
    byte_valid = 1'b0;
    chk("over_load_err", {31'd0, load_err}, 32'd1);
    chk("over_ready_seen", {31'd0, ready_seen}, 32'd0);
    chk("over_no_writes", 32'(wr_cnt - w0), 32'd0);
    $display("load wc=65 rejected");

    // Reset after two bytes of a three-word load.
    w0 = wr_cnt;
    pulse_start(16'd3);
    chk("start_clears_err", {31'd0, load_err}, 32'd0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("mid_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("mid_rst_wr_addr", wr_addr, 32'h0);
    chk("mid_rst_wr_data", wr_data, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid_rst_no_writes", 32'(wr_cnt - w0), 32'd0);
    byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back('{32'h0000_0000, 32'hDEAD_BEEF});
    run_load(1, 0);
    $display("reload after reset done");

    // load_start pulsed mid-load is ignored.
    d0 = done_cnt;
    exp_q.push_back('{32'h0000_0000, 32'hA1B2_C3D4});
    exp_q.push_back('{32'h0000_0004, 32'h0F1E_2D3C});
    pulse_start(16'd2);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    send_byte(8'h0F, 0);
    send_byte(8'h1E, 0);
    pulse_start(16'd5);
    send_byte(8'h2D, 0);
    send_byte(8'h3C, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    cs = 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4 ^ 8'h0F ^ 8'h1E ^ 8'h2D ^ 8'h3C;
    send_byte(cs, 0);
`endif
    wait_done(d0);
    chk("midstart_addr", wr_addr, 32'h0000_0008);
    chk("midstart_scoreboard", 32'(exp_q.size()), 32'd0);
    $display("mid-load start ignored");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // XOR of 11,22,33,44 is 44.
    foreach (byte_q[i]) cs = 8'h00;
    cs = 8'h44;
    d0 = done_cnt;
    exp_q.push_back('{32'h0000_0000, 32'h1122_3344});
    pulse_start(16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(cs, 0);
    wait_done(d0);
    chk("csum_good_err", {31'd0, load_err}, 32'd0);
    d0 = done_cnt;
    exp_q.push_back('{32'h0000_0000, 32'h1122_3344});
    pulse_start(16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'hFF, 0);
    wait_done(d0);
    chk("csum_bad_err", {31'd0, load_err}, 32'd1);
    chk("csum_data_kept", wr_data, 32'h1122_3344);
    $display("checksum loads done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
